// File: rtl/mp3_side_info_pkg.sv
// rtl/mp3_side_info_pkg.sv - shared widths, frame sizes and FSM states for the side-info packer
package mp3_side_info_pkg;

  localparam int MDB_W = 9;
  localparam int PB_W  = 3;
  localparam int P23_W = 12;
  localparam int BV_W  = 9;
  localparam int GG_W  = 8;
  localparam int SFC_W = 4;
  localparam int TS_W  = 5;
  localparam int SBG_W = 3;

  localparam int SIDE_INFO_BITS = 256;
  localparam int GRCH_BITS      = 59;
  localparam int HDR_BITS       = 20;
  localparam int BRANCH_BITS    = 22;
  localparam int FRAME_BYTES    = SIDE_INFO_BITS / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } pack_state_t;

endpackage

// File: rtl/side_info_2ch_assemble.sv
// rtl/side_info_2ch_assemble.sv - combinational assembly of the 256-bit stereo side-info vector
module side_info_2ch_assemble
  import mp3_side_info_pkg::*;
(
  input  logic [MDB_W-1:0]                 main_data_begin,
  input  logic [PB_W-1:0]                  private_bits,
  input  logic [1:0][3:0]                  scfsi,
  input  logic [1:0][1:0][P23_W-1:0]       part2_3_length,
  input  logic [1:0][1:0][BV_W-1:0]        big_values,
  input  logic [1:0][1:0][GG_W-1:0]        global_gain,
  input  logic [1:0][1:0][SFC_W-1:0]       scalefac_compress,
  input  logic [1:0][1:0]                  window_switching_flag,
  input  logic [1:0][1:0][1:0]             block_type,
  input  logic [1:0][1:0]                  mixed_block_flag,
  input  logic [1:0][1:0][2:0][TS_W-1:0]   table_select,
  input  logic [1:0][1:0][2:0][SBG_W-1:0]  subblock_gain,
  input  logic [1:0][1:0][3:0]             region0_count,
  input  logic [1:0][1:0][3:0]             region1_count,
  input  logic [1:0][1:0]                  preflag,
  input  logic [1:0][1:0]                  scalefac_scale,
  input  logic [1:0][1:0]                  count1table_select,
  output logic [SIDE_INFO_BITS-1:0]        vec
);

  logic [GRCH_BITS-1:0] slice [4];

  // region1_count[3] has no slot in the bitstream; it is deliberately dropped
  logic unused_region1_msb;
  assign unused_region1_msb = ^{region1_count[0][0][3], region1_count[0][1][3],
                                region1_count[1][0][3], region1_count[1][1][3]};

  // One 59-bit slice per granule/channel; the 22-bit middle depends on window switching
  genvar g, c;
  generate
    for (g = 0; g < 2; g++) begin : g_gr
      for (c = 0; c < 2; c++) begin : g_ch
        logic [BRANCH_BITS-1:0] branch;

        assign branch = window_switching_flag[g][c]
          ? {block_type[g][c], mixed_block_flag[g][c],
             table_select[g][c][0], table_select[g][c][1],
             subblock_gain[g][c][0], subblock_gain[g][c][1], subblock_gain[g][c][2]}
          : {table_select[g][c][0], table_select[g][c][1], table_select[g][c][2],
             region0_count[g][c], region1_count[g][c][2:0]};

        assign slice[g*2+c] = {part2_3_length[g][c], big_values[g][c], global_gain[g][c],
                               scalefac_compress[g][c], window_switching_flag[g][c], branch,
                               preflag[g][c], scalefac_scale[g][c], count1table_select[g][c]};
      end
    end
  endgenerate

  // Header first, then slices in gr0ch0, gr0ch1, gr1ch0, gr1ch1 order; bit 255 goes out first
  assign vec = {main_data_begin, private_bits, scfsi[0], scfsi[1],
                slice[0], slice[1], slice[2], slice[3]};

endmodule

// File: rtl/side_info_2ch_packer.sv
// rtl/side_info_2ch_packer.sv - serialises stereo side-info into an MSB-first byte stream
module side_info_2ch_packer
  import mp3_side_info_pkg::*;
#(
  parameter int BYTE_GAP = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [MDB_W-1:0]                 main_data_begin,
  input  logic [PB_W-1:0]                  private_bits,
  input  logic [1:0][3:0]                  scfsi,
  input  logic [1:0][1:0][P23_W-1:0]       part2_3_length,
  input  logic [1:0][1:0][BV_W-1:0]        big_values,
  input  logic [1:0][1:0][GG_W-1:0]        global_gain,
  input  logic [1:0][1:0][SFC_W-1:0]       scalefac_compress,
  input  logic [1:0][1:0]                  window_switching_flag,
  input  logic [1:0][1:0][1:0]             block_type,
  input  logic [1:0][1:0]                  mixed_block_flag,
  input  logic [1:0][1:0][2:0][TS_W-1:0]   table_select,
  input  logic [1:0][1:0][2:0][SBG_W-1:0]  subblock_gain,
  input  logic [1:0][1:0][3:0]             region0_count,
  input  logic [1:0][1:0][3:0]             region1_count,
  input  logic [1:0][1:0]                  preflag,
  input  logic [1:0][1:0]                  scalefac_scale,
  input  logic [1:0][1:0]                  count1table_select,
  output logic [7:0]                       axiod,
  output logic                             axiov,
  output logic                             busy,
  output logic                             done
);

  localparam logic [3:0] GAP_LAST  = (BYTE_GAP > 0) ? 4'(BYTE_GAP - 1) : 4'd0;
  localparam logic [5:0] LAST_BYTE = 6'(FRAME_BYTES - 1);
  localparam logic [5:0] ALL_SENT  = 6'(FRAME_BYTES);

  pack_state_t               state, state_nx;
  logic [SIDE_INFO_BITS-1:0] vec;
  logic [SIDE_INFO_BITS-1:0] sr;
  logic [5:0]                byte_cnt;
  logic [3:0]                gap_cnt;
  logic [7:0]                hold;
  logic                      load;

  side_info_2ch_assemble u_assemble (
    .main_data_begin       (main_data_begin),
    .private_bits          (private_bits),
    .scfsi                 (scfsi),
    .part2_3_length        (part2_3_length),
    .big_values            (big_values),
    .global_gain           (global_gain),
    .scalefac_compress     (scalefac_compress),
    .window_switching_flag (window_switching_flag),
    .block_type            (block_type),
    .mixed_block_flag      (mixed_block_flag),
    .table_select          (table_select),
    .subblock_gain         (subblock_gain),
    .region0_count         (region0_count),
    .region1_count         (region1_count),
    .preflag               (preflag),
    .scalefac_scale        (scalefac_scale),
    .count1table_select    (count1table_select),
    .vec                   (vec)
  );

  // Next-state logic; a new frame is only accepted from IDLE or FIN
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (BYTE_GAP > 0) begin
          state_nx = ST_GAP;
        end else if (byte_cnt == LAST_BYTE) begin
          state_nx = ST_FIN;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = (byte_cnt == ALL_SENT) ? ST_FIN : ST_SEND;
        end
      end
      ST_FIN: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ST_SEND;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, shift register, counters and last-byte hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sr       <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      hold     <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        sr       <= vec;
        byte_cnt <= '0;
        gap_cnt  <= '0;
      end else if (state == ST_SEND) begin
        sr       <= {sr[SIDE_INFO_BITS-9:0], 8'h00};
        byte_cnt <= byte_cnt + 6'd1;
        gap_cnt  <= '0;
        hold     <= sr[SIDE_INFO_BITS-1 -: 8];
      end else if (state == ST_GAP) begin
        gap_cnt  <= gap_cnt + 4'd1;
      end
    end
  end

  assign axiov = (state == ST_SEND);
  assign busy  = (state == ST_SEND) || (state == ST_GAP);
  assign done  = (state == ST_FIN);
  assign axiod = axiov ? sr[SIDE_INFO_BITS-1 -: 8] : hold;

endmodule

// File: tb/tb_side_info_2ch_packer.sv
// tb/tb_side_info_2ch_packer.sv - directed self-checking bench for side_info_2ch_packer
module tb_side_info_2ch_packer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_g;

  logic [8:0]                main_data_begin;
  logic [2:0]                private_bits;
  logic [1:0][3:0]           scfsi;
  logic [1:0][1:0][11:0]     part2_3_length;
  logic [1:0][1:0][8:0]      big_values;
  logic [1:0][1:0][7:0]      global_gain;
  logic [1:0][1:0][3:0]      scalefac_compress;
  logic [1:0][1:0]           window_switching_flag;
  logic [1:0][1:0][1:0]      block_type;
  logic [1:0][1:0]           mixed_block_flag;
  logic [1:0][1:0][2:0][4:0] table_select;
  logic [1:0][1:0][2:0][2:0] subblock_gain;
  logic [1:0][1:0][3:0]      region0_count;
  logic [1:0][1:0][3:0]      region1_count;
  logic [1:0][1:0]           preflag;
  logic [1:0][1:0]           scalefac_scale;
  logic [1:0][1:0]           count1table_select;

  logic [7:0] axiod, g_axiod;
  logic       axiov, g_axiov;
  logic       busy, g_busy;
  logic       done, g_done;

  logic [7:0] exp_b [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  side_info_2ch_packer #(.BYTE_GAP(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .main_data_begin(main_data_begin), .private_bits(private_bits), .scfsi(scfsi),
    .part2_3_length(part2_3_length), .big_values(big_values), .global_gain(global_gain),
    .scalefac_compress(scalefac_compress), .window_switching_flag(window_switching_flag),
    .block_type(block_type), .mixed_block_flag(mixed_block_flag),
    .table_select(table_select), .subblock_gain(subblock_gain),
    .region0_count(region0_count), .region1_count(region1_count),
    .preflag(preflag), .scalefac_scale(scalefac_scale),
    .count1table_select(count1table_select),
    .axiod(axiod), .axiov(axiov), .busy(busy), .done(done)
  );

  side_info_2ch_packer #(.BYTE_GAP(2)) dut_gap (
    .clk(clk), .rst(rst), .start(start_g),
    .main_data_begin(main_data_begin), .private_bits(private_bits), .scfsi(scfsi),
    .part2_3_length(part2_3_length), .big_values(big_values), .global_gain(global_gain),
    .scalefac_compress(scalefac_compress), .window_switching_flag(window_switching_flag),
    .block_type(block_type), .mixed_block_flag(mixed_block_flag),
    .table_select(table_select), .subblock_gain(subblock_gain),
    .region0_count(region0_count), .region1_count(region1_count),
    .preflag(preflag), .scalefac_scale(scalefac_scale),
    .count1table_select(count1table_select),
    .axiod(g_axiod), .axiov(g_axiov), .busy(g_busy), .done(g_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_fields();
    main_data_begin       = '0;
    private_bits          = '0;
    scfsi                 = '0;
    part2_3_length        = '0;
    big_values            = '0;
    global_gain           = '0;
    scalefac_compress     = '0;
    window_switching_flag = '0;
    block_type            = '0;
    mixed_block_flag      = '0;
    table_select          = '0;
    subblock_gain         = '0;
    region0_count         = '0;
    region1_count         = '0;
    preflag               = '0;
    scalefac_scale        = '0;
    count1table_select    = '0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) exp_b[i] = 8'h00;
  endtask

  // Start a frame on the zero-gap instance, scramble fields afterwards, check all 32 bytes
  task automatic run_frame(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear_fields();
    main_data_begin = 9'h0AA;
    for (int k = 0; k < 32; k++) begin
      check($sformatf("%s_v%0d", tag, k), {31'd0, axiov}, 32'd1);
      check($sformatf("%s_b%0d", tag, k), {24'd0, axiod}, {24'd0, exp_b[k]});
      if (k == 0 || k == 31) check($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_fin_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_fin_v"}, {31'd0, axiov}, 32'd0);
    check({tag, "_hold"}, {24'd0, axiod}, {24'd0, exp_b[31]});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    clear_fields();
  endtask

  initial begin
    int npulse, ndone, done_c, nv;
    rst = 1'b1;
    start = 1'b0;
    start_g = 1'b0;
    clear_fields();
    repeat (3) @(negedge clk);
    check("rst_axiod", {24'd0, axiod}, 32'd0);
    check("rst_axiov", {31'd0, axiov}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    clear_exp();
    main_data_begin = 9'h1EB;
    exp_b[0] = 8'hF5; exp_b[1] = 8'h80;
    run_frame("mdb");

    clear_exp();
    part2_3_length[0][0] = 12'hFFF;
    exp_b[2] = 8'h0F; exp_b[3] = 8'hFF;
    run_frame("p23");

    clear_exp();
    window_switching_flag[0][0] = 1'b1;
    block_type[0][0] = 2'b10;
    region0_count[0][0] = 4'hF;
    table_select[0][0][2] = 5'h1F;
    exp_b[6] = 8'h06;
    run_frame("wsf1");

    clear_exp();
    private_bits = 3'b111;
    scfsi[1] = 4'hF;
    exp_b[1] = 8'h70; exp_b[2] = 8'hF0;
    run_frame("hdr");

    clear_exp();
    region1_count[0][0] = 4'hF;
    subblock_gain[0][0] = {3'd7, 3'd7, 3'd7};
    mixed_block_flag[0][0] = 1'b1;
    block_type[0][0] = 2'b11;
    exp_b[9] = 8'h70;
    run_frame("wsf0");

    clear_exp();
    window_switching_flag[1][1] = 1'b1;
    subblock_gain[1][1][2] = 3'd7;
    count1table_select[1][1] = 1'b1;
    exp_b[28] = 8'h02; exp_b[31] = 8'h39;
    run_frame("gr1ch1");

    // Gap instance: pulse spacing and done timing
    main_data_begin = 9'h1EB;
    @(negedge clk);
    start_g = 1'b1;
    @(negedge clk);
    start_g = 1'b0;
    check("gap_b0", {24'd0, g_axiod}, 32'h0000_00F5);
    npulse = 0; ndone = 0; done_c = 0;
    for (int c = 1; c <= 110; c++) begin
      if (g_axiov) begin
        check($sformatf("gap_t%0d", npulse), c, 1 + 3 * npulse);
        npulse++;
      end
      if (g_done) begin
        ndone++;
        done_c = c;
      end
      @(negedge clk);
    end
    check("gap_pulses", npulse, 32);
    check("gap_ndone", ndone, 1);
    check("gap_done_cycle", done_c, 97);
    clear_fields();

    // Reset mid-frame aborts without done
    main_data_begin = 9'h1EB;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_pre_v", {31'd0, axiov}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_v", {31'd0, axiov}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);

    // rst and start together: rst wins
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_v", {31'd0, axiov}, 32'd0);
    check("rst_start_busy", {31'd0, busy}, 32'd0);

    // start while busy is ignored, exactly one frame emitted
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    nv = 0; ndone = 0;
    for (int c = 0; c < 80; c++) begin
      if (axiov) nv++;
      if (done) ndone++;
      start = (c == 5 || c == 15 || c == 25);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start_bytes", nv, 32);
    check("busy_start_done", ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/side_info_2ch_packer.md
# side_info_2ch_packer

Serialises one MPEG-1 Layer III stereo side-information block (256 bits, 32 bytes) from parallel fields into an MSB-first byte stream. It is the transmit-side counterpart of `side_info_2ch` and accepts exactly the field set that parser produces. It sits in the encoder/loopback path, ahead of the frame assembler. Its output stream is directly consumable by `side_info_2ch`.

## Interface
Parameters:
- `BYTE_GAP`, default 0: idle cycles (`axiov` low) inserted after each byte. Range 0–15.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: load all field inputs and begin a frame. Ignored while `busy`.
- `main_data_begin` in 9; `private_bits` in 3; `scfsi` in [1:0][3:0] ([ch][band]).
- `part2_3_length` in [1:0][1:0][11:0]; `big_values` in [1:0][1:0][8:0]; `global_gain` in [1:0][1:0][7:0]; `scalefac_compress` in [1:0][1:0][3:0]. All [gr][ch].
- `window_switching_flag`, `mixed_block_flag`, `preflag`, `scalefac_scale`, `count1table_select` in [1:0][1:0]; `block_type` in [1:0][1:0][1:0].
- `table_select` in [1:0][1:0][2:0][4:0] ([gr][ch][region]); `subblock_gain` in [1:0][1:0][2:0][2:0] ([gr][ch][window]).
- `region0_count` in [1:0][1:0][3:0]; `region1_count` in [1:0][1:0][3:0] (only bits [2:0] transmitted).
- `axiod` out 8: output byte. `axiov` out 1: byte valid, one-cycle pulse per byte.
- `busy` out 1: frame in progress. `done` out 1: one-cycle pulse at end of frame.

## Operation
- Bit order is MSB first. Bit 0 of the stream is `axiod[7]` of byte 0.
- Header, 20 bits: `main_data_begin`, `private_bits`, then `scfsi[0][3:0]`, then `scfsi[1][3:0]`.
- Four 59-bit slices follow in order gr0ch0, gr0ch1, gr1ch0, gr1ch1. Each slice carries, in order:
  - `part2_3_length` 12, `big_values` 9, `global_gain` 8, `scalefac_compress` 4, `window_switching_flag` 1.
  - If the flag is 1: `block_type` 2, `mixed_block_flag` 1, `table_select[0..1]` 5 each, `subblock_gain[0..2]` 3 each.
  - If the flag is 0: `table_select[0..2]` 5 each, `region0_count` 4, `region1_count[2:0]` 3.
  - Both branches are 22 bits. The slice ends with `preflag`, `scalefac_scale`, `count1table_select`.
- Total: 20 + 4×59 = 256 bits.
- When the flag is 0, `block_type`, `mixed_block_flag` and `subblock_gain` are not transmitted. When the flag is 1, `table_select[2]` and the region counts are not transmitted.
- FSM states:
  - IDLE: on `start`, latch the assembled 256-bit vector into the shift register, clear the byte counter and gap counter, go to SEND.
  - SEND: present the top byte with `axiov`=1, shift left 8, increment the byte counter. If `BYTE_GAP`>0, go to GAP. After byte 31, go to FIN.
  - GAP: count `BYTE_GAP` cycles with `axiov`=0, then return to SEND.
  - FIN: `done`=1, `busy`=0, return to IDLE.
- `start` asserted in FIN or IDLE is accepted. `start` in SEND or GAP is ignored; it is not queued.
- Field inputs are sampled only in the `start` cycle. Later changes do not affect the frame in flight.

## Timing
- Reset values: `axiod`=0, `axiov`=0, `busy`=0, `done`=0, state IDLE, shift register 0.
- `rst` mid-frame aborts the frame: `axiov`=0 from the next cycle. No `done` is issued.
- With `start` sampled at cycle t:
  - byte k (0..31) has `axiov`=1 at cycle t+1+k·(`BYTE_GAP`+1);
  - `done` at cycle t+32·(`BYTE_GAP`+1)+1 when `BYTE_GAP`=0, or at the cycle after the final gap when `BYTE_GAP`>0;
  - `busy`=1 from t+1 through the last byte/gap cycle.
- `axiod` holds its last value when `axiov`=0.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure
- Package `mp3_side_info_pkg` holds:
  - width constants (`MDB_W`=9, `P23_W`=12, `BV_W`=9, `GG_W`=8, `SFC_W`=4, `TS_W`=5, `SBG_W`=3);
  - `SIDE_INFO_BITS`=256, `GRCH_BITS`=59, `HDR_BITS`=20;
  - an FSM state enum.
- Combinational sub-module `side_info_2ch_assemble` builds the 256-bit vector from the fields. The top module owns the FSM, the shift register and the counters.

## Test plan
- `main_data_begin`=9'h1EB, all other fields 0, `BYTE_GAP`=0 -> bytes F5 80 00 … 00 on 32 consecutive cycles, then `done` for one cycle.
- `part2_3_length[0][0]`=12'hFFF, rest 0 -> byte2=0F, byte3=FF, all other bytes 00.
- gr0ch0 `window_switching_flag`=1, `block_type`=2'b10, `region0_count`=4'hF -> byte6=06; no region bits appear.
- `BYTE_GAP`=2, any frame -> `axiov` pulses every 3 cycles, 32 pulses total, `done` 96 cycles after the first pulse.
- Loopback into `side_info_2ch` with random fields (region1 < 8) -> every parser output equals the packer input. Inactive-branch fields are excluded from the comparison.
- `rst` after byte 10 -> `axiov` low from the next cycle and no `done`. Then `start` pulses while `busy` -> ignored, and only one frame of 32 bytes is emitted.
